// File: rtl/uart_tx_feeder.sv
// Transmit FIFO plus launcher that feeds one word at a time into the UART driver's start/ready/busy handshake.
// Optional build macro UART_FEEDER_FLUSH_EN adds a synchronous flush input.
module uart_tx_feeder #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     uart_start,
  output logic [WIDTH-1:0]         uart_data,
  input  logic                     uart_ready,
  input  logic                     uart_busy
`ifdef UART_FEEDER_FLUSH_EN
  ,
  input  logic                     flush
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_nxt;
  logic             flush_w;
  logic             wr_acc;
  logic             launch;
  state_t           state;
  state_t           state_nxt;

`ifdef UART_FEEDER_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  function automatic logic [LW-1:0] level_step(input logic [LW-1:0] lvl,
                                               input logic          inc,
                                               input logic          dec);
    case ({inc, dec})
      2'b10:   return lvl + LW'(1);
      2'b01:   return lvl - LW'(1);
      default: return lvl;
    endcase
  endfunction

  // A write is judged against the registered full flag, so a same-cycle pop never rescues it.
  assign wr_acc    = wr_en && !full && !flush_w;
  assign level_nxt = level_step(level, wr_acc, launch);

  // FIFO storage: contents are never reset, only the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else if (flush_w) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (launch) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_nxt;
      full  <= (level_nxt == LW'(DEPTH));
      empty <= (level_nxt == '0);
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Launcher state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && uart_ready && !flush_w) begin
          launch    = 1'b1;
          state_nxt = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (uart_busy) begin
          state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!uart_busy && uart_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Driver-facing outputs: start is a registered pulse, data holds until the next launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_start <= 1'b0;
      uart_data  <= '0;
    end else begin
      uart_start <= launch;
      if (launch) begin
        uart_data <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: stimulus queues expected launch words, a monitor checks each uart_start.
`timescale 1ns/1ps
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int WIDTH = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic             empty;
  logic [4:0]       level;
  logic             overflow;
  logic             uart_start;
  logic [WIDTH-1:0] uart_data;
  logic             uart_ready;
  logic             uart_busy;
  logic             ready_drv;
  logic             ready_gate;
`ifdef UART_FEEDER_FLUSH_EN
  logic             flush;
`endif

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int busy_len = 3;
  int max_level = 0;
  logic prev_start = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  uart_tx_feeder #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow),
    .uart_start (uart_start),
    .uart_data  (uart_data),
    .uart_ready (uart_ready),
    .uart_busy  (uart_busy)
`ifdef UART_FEEDER_FLUSH_EN
    ,
    .flush      (flush)
`endif
  );

  always #5 clk = ~clk;
  assign uart_ready = ready_drv & ready_gate;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver model: samples the start pulse at the edge, then goes busy for busy_len cycles.
  initial begin
    uart_busy = 1'b0;
    ready_drv = 1'b1;
    forever begin
      @(posedge clk);
      if (uart_start && !rst) begin
        #1;
        uart_busy = 1'b1;
        ready_drv = 1'b0;
        repeat (busy_len) @(posedge clk);
        #1;
        uart_busy = 1'b0;
        ready_drv = 1'b1;
      end
    end
  end

  // Monitor: every launch must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (int'(level) > max_level) max_level = int'(level);
      if (uart_start) begin
        start_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_start", {23'd0, uart_data}, 32'h1ff_ffff);
        end else begin
          check("uart_data", {23'd0, uart_data}, {23'd0, exp_q.pop_front()});
        end
        check("start_back_to_back", {31'd0, prev_start}, 32'd0);
        check("start_while_busy", {31'd0, uart_busy}, 32'd0);
      end
      prev_start = uart_start;
    end else begin
      prev_start = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [WIDTH-1:0] d, input logic expect_launch);
    wr_en   = 1'b1;
    wr_data = d;
    if (expect_launch) exp_q.push_back(d);
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick(1);
      n++;
    end
    check({name, "_timeout"}, {31'd0, n < max_cyc}, 32'd1);
    tick(busy_len + 8);
  endtask

  task automatic wait_driver_idle(input int max_cyc);
    int n = 0;
    while ((uart_busy || !ready_drv) && n < max_cyc) begin
      tick(1);
      n++;
    end
    check("driver_idle_timeout", {31'd0, n < max_cyc}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    int sc;
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_data    = '0;
    ready_gate = 1'b1;
`ifdef UART_FEEDER_FLUSH_EN
    flush      = 1'b0;
`endif
    tick(3);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_level", {27'd0, level}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_start", {31'd0, uart_start}, 32'd0);
    check("rst_data", {23'd0, uart_data}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Single word: pulse exactly one cycle after the write edge
    wr_word(9'h0A5, 1'b1);
    check("single_level1", {27'd0, level}, 32'd1);
    check("single_empty0", {31'd0, empty}, 32'd0);
    check("single_start_early", {31'd0, uart_start}, 32'd0);
    tick(1);
    check("single_start", {31'd0, uart_start}, 32'd1);
    check("single_data", {23'd0, uart_data}, 32'h0A5);
    check("single_level0", {27'd0, level}, 32'd0);
    tick(1);
    check("single_start_off", {31'd0, uart_start}, 32'd0);
    check("single_data_hold", {23'd0, uart_data}, 32'h0A5);
    drain("single", 50);

    // Reset in WAIT_DONE with five words queued
    busy_len = 20;
    wr_word(9'h011, 1'b1);
    for (int i = 0; i < 5; i++) wr_word(9'h020 + 9'(i), 1'b0);
    check("pre_rst_level", {27'd0, level}, 32'd5);
    tick(2);
    sc = start_cnt;
    rst = 1'b1;
    #1;
    check("midrst_empty", {31'd0, empty}, 32'd1);
    check("midrst_level", {27'd0, level}, 32'd0);
    check("midrst_start", {31'd0, uart_start}, 32'd0);
    check("midrst_data", {23'd0, uart_data}, 32'd0);
    tick(1);
    rst = 1'b0;
    wait_driver_idle(100);
    tick(3);
    check("post_rst_empty", {31'd0, empty}, 32'd1);
    check("post_rst_no_start", start_cnt, sc);
    busy_len = 3;
    wr_word(9'h0C3, 1'b1);
    tick(1);
    check("post_rst_idle_launch", {31'd0, uart_start}, 32'd1);
    drain("post_rst", 50);

    // Fill with the driver held off, then one dropped word
    ready_gate = 1'b0;
    for (int i = 0; i < 16; i++) wr_word(9'h100 + 9'(i), 1'b1);
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_level", {27'd0, level}, 32'd16);
    check("fill_no_overflow", {31'd0, overflow}, 32'd0);
    wr_word(9'h110, 1'b0);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_level", {27'd0, level}, 32'd16);
    check("ovf_full", {31'd0, full}, 32'd1);
    ready_gate = 1'b1;
    drain("burst", 1000);
    check("burst_empty", {31'd0, empty}, 32'd1);
    check("burst_level", {27'd0, level}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Handshake gating: long busy holds the second word back
    busy_len = 200;
    sc = start_cnt;
    wr_word(9'h055, 1'b1);
    wr_word(9'h0AA, 1'b1);
    tick(150);
    check("gate_one_start", start_cnt, sc + 1);
    check("gate_level", {27'd0, level}, 32'd1);
    drain("gate", 500);
    check("gate_two_starts", start_cnt, sc + 2);
    busy_len = 2;

    // Wrap-around: five bursts of eight words, pointers wrap twice
    max_level = 0;
    sc = start_cnt;
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 8; i++) wr_word(9'h040 + 9'(b * 8 + i), 1'b1);
      tick(30);
    end
    drain("wrap", 1000);
    check("wrap_count", start_cnt, sc + 40);
    check("wrap_max_level", {31'd0, max_level <= 16}, 32'd1);

    // Write and pop in the same cycle at full: write dropped
    do_reset();
    check("rst2_overflow", {31'd0, overflow}, 32'd0);
    ready_gate = 1'b0;
    for (int i = 0; i < 16; i++) wr_word(9'h1E0 + 9'(i), 1'b1);
    check("full2_level", {27'd0, level}, 32'd16);
    ready_gate = 1'b1;
    wr_word(9'h1FF, 1'b0);
    check("simul_level", {27'd0, level}, 32'd15);
    check("simul_overflow", {31'd0, overflow}, 32'd1);
    check("simul_full", {31'd0, full}, 32'd0);
    drain("simul", 1000);

`ifdef UART_FEEDER_FLUSH_EN
    // Flush with a frame in flight
    busy_len = 30;
    wr_word(9'h0F0, 1'b1);
    for (int i = 0; i < 7; i++) wr_word(9'h0E0 + 9'(i), 1'b0);
    check("preflush_level", {27'd0, level}, 32'd7);
    sc = start_cnt;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("flush_level", {27'd0, level}, 32'd0);
    check("flush_empty", {31'd0, empty}, 32'd1);
    check("flush_overflow", {31'd0, overflow}, 32'd0);
    wait_driver_idle(100);
    tick(10);
    check("flush_no_start", start_cnt, sc);
    busy_len = 3;
`endif

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Transmit-side buffer and launcher that sits directly upstream of the UART driver. It accepts 9-bit words from a host write port into a power-of-two FIFO. It pops one word at a time and hands it to the driver through its `UART_Start` / `UART_Ready` / `UART_Busy` handshake, so the host never has to poll transmit status between bytes.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥2.
- `WIDTH`, 9, word width; matches the driver's `data_in`.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `wr_en`  in  1  host write strobe; one word per cycle.
- `wr_data`  in  WIDTH  host write word.
- `full`  out  1  FIFO holds DEPTH words.
- `empty`  out  1  FIFO holds 0 words.
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; set when a write is dropped.
- `uart_start`  out  1  one-cycle launch pulse to the driver's `UART_Start`.
- `uart_data`  out  WIDTH  word to the driver's `data_in`.
- `uart_ready`  in  1  from the driver's `UART_Ready`.
- `uart_busy`  in  1  from the driver's `UART_Busy`.
- `flush`  in  1  present only with `UART_FEEDER_FLUSH_EN`; see Configuration.

## Operation
- **FIFO**
  - Circular buffer with read and write pointers of $clog2(DEPTH) bits; both wrap modulo DEPTH.
  - `level` is a separate registered counter.
  - Write is accepted when `wr_en` is high and `full` is low.
  - `wr_en` with `full` high drops the word, leaves the FIFO unchanged and sets `overflow`. This holds even if a pop happens in the same cycle, because `full` is the registered value.
  - Simultaneous accepted write and pop: `level` is unchanged and both pointers advance.
- **Launcher FSM**
  - IDLE: if `empty` is low and `uart_ready` is high:
    - register the head word into `uart_data`;
    - assert `uart_start` for one cycle;
    - pop the FIFO;
    - go to WAIT_BUSY.
  - WAIT_BUSY: stay until `uart_busy` is high, then go to WAIT_DONE. `uart_start` is low in this state; the pulse is never repeated.
  - WAIT_DONE: stay until `uart_busy` is low and `uart_ready` is high, then go to IDLE.
- **Output rules**
  - `uart_data` holds its value from launch until the next launch.
  - `full`, `empty` and `level` are registered, consistent with each other and updated on the edge after the write or pop.
- **Reset** (asynchronous, at any point, including mid-frame):
  - both pointers and `level` go to 0;
  - the FSM goes to IDLE;
  - outputs take their reset values;
  - FIFO contents are discarded.
- **Output reset values:** `full`=0, `empty`=1, `level`=0, `overflow`=0, `uart_start`=0, `uart_data`=0.

## Timing
- A word written at edge E into an empty FIFO, with the FSM in IDLE and `uart_ready` high:
  - `empty` falls after E;
  - `uart_start` is high from E+1 to E+2;
  - the driver samples it at E+2.
- A write and an eligible launch never occur for the same word in the same cycle. Minimum write-to-start latency is 1 cycle.
- Back-to-back words: the next `uart_start` comes no earlier than 1 cycle after the FSM re-enters IDLE.
- `uart_start` is never high on two consecutive cycles.

## Configuration
- `UART_FEEDER_FLUSH_EN` defined:
  - adds input `flush`;
  - `flush` high at an edge sets both pointers and `level` to 0, forces `empty`=1 and clears `overflow`;
  - a word already launched completes and the FSM state is untouched;
  - `flush` has priority over a same-cycle `wr_en` (the word is dropped, `overflow` not set) and over a same-cycle launch (no launch that cycle).
- `UART_FEEDER_FLUSH_EN` undefined: no `flush` port, and `overflow` clears only on `rst`.

## Test plan
- **Reset:** assert `rst` mid-WAIT_DONE with `level`=5 -> `empty`=1, `level`=0, `uart_start`=0, `uart_data`=0, FSM IDLE.
- **Single word:** write 0x0A5 with `uart_ready`=1 -> `uart_start` is a single 1-cycle pulse one cycle later, `uart_data`=0x0A5, `level` returns to 0.
- **Burst / fill / overflow:**
  - hold `uart_ready`=0 and write 17 words 0x100..0x110 with DEPTH=16 -> `full`=1, `level`=16, `overflow`=1, and 0x110 is dropped;
  - then release `uart_ready` -> words are launched 0x100..0x10F in order.
- **Handshake gating:** hold `uart_busy`=1 for 200 cycles after a launch -> no further `uart_start` until `uart_busy`=0 and `uart_ready`=1.
- **Wrap-around:**
  - 40 words streamed with interleaved writes and pops -> output order is exact;
  - `level` never exceeds 16 and pointers wrap cleanly;
  - a simultaneous write and pop at `level`=16 drops the write and sets `overflow`.
- **Flush** (`UART_FEEDER_FLUSH_EN` only): `flush` at `level`=7 with a frame in flight -> `level`=0, `overflow`=0, the in-flight frame completes, and no further `uart_start`.
